conv_channel_accumulator: RTL and testbench

Multi-lane partial-sum accumulator placed between the convolver engines and the activation stage of a convolution layer. It sums per-position convolution results across a configurable number of input channels in an internal buffer. On the last channel it applies rounding, arithmetic shift, saturation and optional ReLU. It emits the quantised result through a valid/ready stream, replacing the single-pass accumulate-previous scheme with full multi-channel operation and backpressure.

---
 rtl/conv_channel_accumulator.sv | 251 +++++++++++++++++++++++++
 tb/tb_conv_channel_accumulator.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_accumulator.sv
// conv_channel_accumulator
// Multi-lane partial-sum accumulator sitting between the convolver engines and
// the activation stage. Partial sums for each output position are summed over
// all input channels in a per-lane buffer; the last channel is quantised
// (round, arithmetic shift, saturate, optional ReLU) and streamed out through
// a valid/ready interface.
module conv_channel_accumulator #(
  parameter int N          = 16,
  parameter int InWidth    = 32,
  parameter int Lanes      = 4,
  parameter int MaxOutputs = 1024,
  parameter int AccWidth   = InWidth + 8,
  parameter int CntW       = $clog2(MaxOutputs + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic [7:0]                      channel_count_i,
  input  logic [CntW-1:0]                 output_count_i,
  input  logic [5:0]                      shift_i,
  input  logic                            round_i,
  input  logic                            relu_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [Lanes-1:0][InWidth-1:0]   in_data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [Lanes-1:0][N-1:0]         out_data_o,
  output logic [7:0]                      channel_o,
  output logic                            busy_o,
  output logic                            done_o
);

  localparam int AddrW = (MaxOutputs > 1) ? $clog2(MaxOutputs) : 1;

  // Saturation limits held at accumulator-plus-one width so comparisons stay signed.
  localparam logic signed [AccWidth:0] SatMax = (AccWidth + 1)'(2 ** (N - 1) - 1);
  localparam logic signed [AccWidth:0] SatMin = (AccWidth + 1)'(-(2 ** (N - 1)));

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state_q, state_d;
  logic   done_d;

  // Latched pass configuration; counts are stored as "last index" values.
  logic [7:0]      chan_last_q;
  logic [CntW-1:0] pos_last_q;
  logic [5:0]      shift_q;
  logic            round_q;
  logic            relu_q;

  // Position / channel counters.
  logic [CntW-1:0] pos_q;
  logic [7:0]      chan_q;

  // Per-lane partial-sum storage; contents have no reset value.
  logic [AccWidth-1:0] acc_mem [Lanes][MaxOutputs];

  // Write-back register: buffer updates are committed one cycle after accept.
  logic                wr_pend_q;
  logic [AddrW-1:0]    wr_addr_q;
  logic [AccWidth-1:0] wr_data_q [Lanes];

  logic                accept;
  logic                is_first;
  logic                is_last;
  logic                pos_wrap;
  logic [AddrW-1:0]    rd_addr;
  logic [AccWidth-1:0] sum_w [Lanes];
  logic [N-1:0]        q_w   [Lanes];

  assign is_first = (chan_q == 8'd0);
  assign is_last  = (chan_q == chan_last_q);
  assign pos_wrap = (pos_q == pos_last_q);
  assign rd_addr  = pos_q[AddrW-1:0];
  assign accept   = in_valid_i && in_ready_o;
  assign channel_o = chan_q;
  assign busy_o    = (state_q != IDLE);

  // Round half-up, arithmetic shift, saturate to N bits and optional ReLU.
  // Shifts beyond the accumulator width behave exactly like a shift equal to it,
  // so the amount is clamped to keep the working width small.
  function automatic logic [N-1:0] quantise(
    input logic signed [AccWidth-1:0] s,
    input logic [5:0]                 shift,
    input logic                       rnd,
    input logic                       relu
  );
    logic signed [AccWidth:0] t;
    logic [N-1:0]             r;
    int                       sh;
    sh = (int'(shift) > AccWidth) ? AccWidth : int'(shift);
    t  = {s[AccWidth-1], s};
    if (rnd && sh > 0) begin
      t = t + ((AccWidth + 1)'(1) << (sh - 1));
    end
    t = t >>> sh;
    if (t > SatMax) begin
      r = SatMax[N-1:0];
    end else if (t < SatMin) begin
      r = SatMin[N-1:0];
    end else begin
      r = t[N-1:0];
    end
    if (relu && t[AccWidth]) begin
      r = '0;
    end
    return r;
  endfunction

  // Input is ready in RUN; in the last channel only when the output slot frees up.
  always_comb begin
    in_ready_o = 1'b0;
    if (state_q == RUN) begin
      in_ready_o = !is_last || !out_valid_o || out_ready_i;
    end
  end

  // Per-lane sum with forwarding of the not-yet-committed write for the same position.
  always_comb begin
    for (int l = 0; l < Lanes; l++) begin
      logic [AccWidth-1:0] rd_word;
      logic [AccWidth-1:0] in_ext;
      logic [AccWidth-1:0] base;
      rd_word = acc_mem[l][rd_addr];
      if (wr_pend_q && (wr_addr_q == rd_addr)) begin
        rd_word = wr_data_q[l];
      end
      in_ext   = {{(AccWidth - InWidth){in_data_i[l][InWidth-1]}}, in_data_i[l]};
      base     = is_first ? '0 : rd_word;
      sum_w[l] = base + in_ext;
      q_w[l]   = quantise(sum_w[l], shift_q, round_q, relu_q);
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> FLUSH on final beat, FLUSH -> IDLE on last handshake.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && is_last && pos_wrap) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_valid_o && out_ready_i) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= done_d;
    end
  end

  // Config capture on start and position/channel stepping on each accepted beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chan_last_q <= 8'd0;
      pos_last_q  <= '0;
      shift_q     <= 6'd0;
      round_q     <= 1'b0;
      relu_q      <= 1'b0;
      pos_q       <= '0;
      chan_q      <= 8'd0;
    end else if ((state_q == IDLE) && start_i) begin
      chan_last_q <= (channel_count_i == 8'd0) ? 8'd0 : channel_count_i - 8'd1;
      pos_last_q  <= (output_count_i == '0) ? '0 : output_count_i - CntW'(1);
      shift_q     <= shift_i;
      round_q     <= round_i;
      relu_q      <= relu_i;
      pos_q       <= '0;
      chan_q      <= 8'd0;
    end else if (accept) begin
      if (pos_wrap) begin
        pos_q <= '0;
        if (!is_last) begin
          chan_q <= chan_q + 8'd1;
        end
      end else begin
        pos_q <= pos_q + CntW'(1);
      end
    end
  end

  // Stage the buffer update for non-last channels; the last channel never writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      for (int l = 0; l < Lanes; l++) begin
        wr_data_q[l] <= '0;
      end
    end else begin
      wr_pend_q <= accept && !is_last;
      if (accept && !is_last) begin
        wr_addr_q <= rd_addr;
        for (int l = 0; l < Lanes; l++) begin
          wr_data_q[l] <= sum_w[l];
        end
      end
    end
  end

  // Commit the staged write into the buffer.
  always_ff @(posedge clk_i) begin
    if (wr_pend_q) begin
      for (int l = 0; l < Lanes; l++) begin
        acc_mem[l][wr_addr_q] <= wr_data_q[l];
      end
    end
  end

  // Output register: load on last-channel accept, hold under backpressure, clear after handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (accept && is_last) begin
      out_valid_o <= 1'b1;
      for (int l = 0; l < Lanes; l++) begin
        out_data_o[l] <= q_w[l];
      end
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_channel_accumulator.sv
// tb_conv_channel_accumulator
// Directed bench for conv_channel_accumulator using a narrow configuration
// (N=8, InWidth=16, Lanes=2). Expected outputs are hand-computed and queued;
// a monitor compares every output handshake against the queue.
module tb_conv_channel_accumulator;

  localparam int N          = 8;
  localparam int InWidth    = 16;
  localparam int Lanes      = 2;
  localparam int MaxOutputs = 8;
  localparam int AccWidth   = InWidth + 8;
  localparam int CntW       = $clog2(MaxOutputs + 1);

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic                          start_i;
  logic [7:0]                    channel_count_i;
  logic [CntW-1:0]               output_count_i;
  logic [5:0]                    shift_i;
  logic                          round_i;
  logic                          relu_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [Lanes-1:0][InWidth-1:0] in_data_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [Lanes-1:0][N-1:0]       out_data_o;
  logic [7:0]                    channel_o;
  logic                          busy_o;
  logic                          done_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int exp0[$];
  int exp1[$];
  int hs_count    = 0;
  int last_hs_cyc = 0;
  int prev_hs     = 0;
  bit rate_arm    = 1'b0;
  bit have_prev   = 1'b0;
  int mon_e0;
  int mon_e1;
  int sink_ch;
  int bp_base;

  int t2_l0 [6] = '{10, 20, 5, -30, 1, 2};
  int t2_l1 [6] = '{1, -1, 2, -2, 3, -3};

  conv_channel_accumulator #(
    .N(N),
    .InWidth(InWidth),
    .Lanes(Lanes),
    .MaxOutputs(MaxOutputs),
    .AccWidth(AccWidth),
    .CntW(CntW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .channel_count_i(channel_count_i),
    .output_count_i(output_count_i),
    .shift_i(shift_i),
    .round_i(round_i),
    .relu_i(relu_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i(in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o(out_data_o),
    .channel_o(channel_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Cycle counter used for latency and throughput checks.
  always @(posedge clk_i) cyc <= cyc + 1;

  // Hard stop in case some wait is never satisfied.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expectOut(input int l0, input int l1);
    exp0.push_back(l0);
    exp1.push_back(l1);
  endtask

  // Output monitor: every handshake (seen at the falling edge before it completes) is scored.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp0.size() == 0) begin
        checkOutput("unexpected_out", 1, 0);
      end else begin
        mon_e0 = exp0.pop_front();
        mon_e1 = exp1.pop_front();
        checkOutput("out_lane0", $signed(out_data_o[0]), mon_e0);
        checkOutput("out_lane1", $signed(out_data_o[1]), mon_e1);
      end
      hs_count++;
      last_hs_cyc = cyc;
      if (rate_arm) begin
        if (have_prev) checkOutput("rate_gap", cyc - prev_hs, 1);
        have_prev = 1'b1;
        prev_hs   = cyc;
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, int'(in_ready_o), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid_o), 0);
    checkOutput({tag, "_out_data"}, int'(out_data_o), 0);
    checkOutput({tag, "_channel"}, int'(channel_o), 0);
    checkOutput({tag, "_busy"}, int'(busy_o), 0);
    checkOutput({tag, "_done"}, int'(done_o), 0);
  endtask

  // All driving tasks start and end just after a rising edge.
  task automatic applyReset(input string tag);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checkResetState(tag);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic startPass(input int ch, input int oc, input int sh, input int rnd, input int relu);
    channel_count_i = 8'(ch);
    output_count_i  = CntW'(oc);
    shift_i         = 6'(sh);
    round_i         = rnd[0];
    relu_i          = relu[0];
    start_i         = 1'b1;
    @(negedge clk_i);
    checkOutput("busy_before_start", int'(busy_o), 0);
    @(posedge clk_i);
    #1;
    start_i         = 1'b0;
    channel_count_i = 8'd5;
    output_count_i  = CntW'(3);
    shift_i         = 6'd7;
    round_i         = 1'b1;
    relu_i          = 1'b1;
    @(negedge clk_i);
    checkOutput("busy_after_start", int'(busy_o), 1);
    @(posedge clk_i);
    #1;
  endtask

  // Present one beat and hold it until accepted; reports channel_o at acceptance.
  task automatic applyStimulus(input int l0, input int l1, output int ch_seen);
    bit ok = 1'b0;
    in_valid_i   = 1'b1;
    in_data_i[0] = InWidth'(l0);
    in_data_i[1] = InWidth'(l1);
    ch_seen      = -1;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        ch_seen = int'(channel_o);
        ok      = 1'b1;
      end
      @(posedge clk_i);
      #1;
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitDone(input string tag);
    bit seen = 1'b0;
    for (int w = 0; w < 60 && !seen; w++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        checkOutput({tag, "_done_lat"}, cyc - last_hs_cyc, 1);
        checkOutput({tag, "_busy_fall"}, int'(busy_o), 0);
      end
      @(posedge clk_i);
      #1;
    end
    if (!seen) begin
      checkOutput({tag, "_done_timeout"}, 0, 1);
    end else begin
      @(negedge clk_i);
      checkOutput({tag, "_done_pulse"}, int'(done_o), 0);
      checkOutput({tag, "_pending"}, exp0.size(), 0);
      @(posedge clk_i);
      #1;
    end
  endtask

  // Single-beat pass used for the quantisation corner cases.
  task automatic onePass(input string tag, input int sh, input int rnd, input int relu,
                         input int l0, input int l1, input int e0, input int e1);
    int ch;
    startPass(1, 1, sh, rnd, relu);
    expectOut(e0, e1);
    applyStimulus(l0, l1, ch);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput({tag, "_valid_lat"}, int'(out_valid_o), 1);
    @(posedge clk_i);
    #1;
    waitDone(tag);
  endtask

  initial begin
    int ch;
    rst_i           = 1'b1;
    start_i         = 1'b0;
    channel_count_i = 8'd0;
    output_count_i  = '0;
    shift_i         = 6'd0;
    round_i         = 1'b0;
    relu_i          = 1'b0;
    in_valid_i      = 1'b0;
    in_data_i       = '0;
    out_ready_i     = 1'b1;

    // Power-on reset, then a beat offered while idle must not be taken.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkResetState("por");
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    checkOutput("idle_in_ready", int'(in_ready_o), 0);
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;

    // Single channel, shift 0: values pass straight through.
    startPass(1, 2, 0, 0, 0);
    expectOut(5, -7);
    expectOut(100, -100);
    applyStimulus(5, -7, ch);
    checkOutput("single_ch0", ch, 0);
    applyStimulus(100, -100, ch);
    in_valid_i = 1'b0;
    waitDone("single");

    // Three channels, two positions.
    startPass(3, 2, 0, 0, 0);
    expectOut(16, 6);
    expectOut(-8, -6);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(t2_l0[i], t2_l1[i], ch);
      checkOutput($sformatf("multi_channel_%0d", i), ch, i / 2);
    end
    in_valid_i = 1'b0;
    waitDone("multi");

    // Saturation at both rails.
    startPass(1, 2, 0, 0, 0);
    expectOut(127, -128);
    expectOut(-128, 127);
    applyStimulus(200, -128, ch);
    applyStimulus(-300, 128, ch);
    in_valid_i = 1'b0;
    waitDone("sat");

    // Rounding, truncation, ReLU and an oversized shift.
    onePass("round", 2, 1, 0, 6, -6, 2, -1);
    onePass("trunc", 2, 0, 0, 6, -6, 1, -2);
    onePass("relu", 2, 1, 1, -6, 6, 0, 2);
    onePass("bigshift", 63, 0, 0, -1, 5, -1, 0);

    // Backpressure: stall the output for 5 cycles mid-stream.
    startPass(1, 6, 0, 0, 0);
    for (int i = 1; i <= 6; i++) expectOut(i, -i);
    bp_base = hs_count;
    fork
      begin
        for (int i = 1; i <= 6; i++) applyStimulus(i, -i, sink_ch);
        in_valid_i = 1'b0;
      end
      begin
        for (int w = 0; w < 50 && hs_count < bp_base + 2; w++) begin
          @(posedge clk_i);
          #1;
        end
        out_ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk_i);
          checkOutput("bp_in_ready", int'(in_ready_o), 0);
          checkOutput("bp_out_valid", int'(out_valid_o), 1);
          checkOutput("bp_hold_lane0", $signed(out_data_o[0]), (exp0.size() > 0) ? exp0[0] : 999);
          checkOutput("bp_hold_lane1", $signed(out_data_o[1]), (exp1.size() > 0) ? exp1[0] : 999);
          @(posedge clk_i);
          #1;
        end
        have_prev   = 1'b0;
        rate_arm    = 1'b1;
        out_ready_i = 1'b1;
      end
    join
    waitDone("bp");
    rate_arm = 1'b0;
    checkOutput("bp_count", hs_count - bp_base, 6);

    // One position, four channels on consecutive cycles.
    startPass(4, 1, 0, 0, 0);
    expectOut(10, -10);
    for (int i = 1; i <= 4; i++) applyStimulus(i, -i, ch);
    in_valid_i = 1'b0;
    waitDone("bypass");

    // Reset during channel 1 with an output pending, then a fresh pass.
    out_ready_i = 1'b0;
    startPass(2, 2, 0, 0, 0);
    applyStimulus(7, 7, ch);
    applyStimulus(8, 8, ch);
    applyStimulus(1, 1, ch);
    checkOutput("mid_channel", ch, 1);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("pre_reset_valid", int'(out_valid_o), 1);
    @(posedge clk_i);
    #1;
    applyReset("midpass_reset");
    out_ready_i = 1'b1;

    startPass(2, 2, 0, 0, 0);
    expectOut(13, -4);
    expectOut(24, 8);
    applyStimulus(3, -5, ch);
    checkOutput("fresh_ch_0", ch, 0);
    start_i         = 1'b1;
    channel_count_i = 8'd1;
    output_count_i  = CntW'(1);
    applyStimulus(4, 7, ch);
    start_i = 1'b0;
    checkOutput("fresh_ch_1", ch, 0);
    checkOutput("busy_start_ignored", int'(busy_o), 1);
    applyStimulus(10, 1, ch);
    checkOutput("fresh_ch_2", ch, 1);
    applyStimulus(20, 1, ch);
    checkOutput("fresh_ch_3", ch, 1);
    in_valid_i = 1'b0;
    waitDone("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
